// File: rtl/exu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exu_div_pkg
// Description : Shared definitions for the execute-unit divider: operand and
//               register-address widths, funct3 op encodings, handshake
//               levels, FSM state type and a conditional-negate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package exu_div_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 5;

  // funct3 encodings of the M-extension divide group
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  localparam logic [REG_W-1:0] ONES_WORD = '1;
  localparam logic [CNT_W-1:0] CNT_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } div_state_e;

  // Two's-complement negate when n is set, pass-through otherwise
  function automatic logic [REG_W-1:0] neg_if(input logic n, input logic [REG_W-1:0] v);
    return n ? (~v + REG_W'(1)) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exu_div.sv
`default_nettype none
// ============================================================================
// Module      : exu_div
// Description : Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
//               One START cycle, 32 CALC cycles (one quotient bit each,
//               MSB first) and one END cycle carrying the result.
//               Optional macro DIV_SPECIAL_FASTPATH_EN: divide-by-zero and
//               signed overflow skip CALC and finish from START.
// Ports       : clk          core clock
//               rst          asynchronous active-low reset
//               start_i      request, held high for the whole operation
//               dividend_i   rs1 value
//               divisor_i    rs2 value
//               op_i         funct3 (1xx = divide group)
//               reg_waddr_i  destination register
//               result_o     quotient/remainder, zero unless ready_o
//               ready_o      one-cycle result-valid pulse
//               busy_o       operation in flight (START/CALC)
//               reg_waddr_o  latched destination register
// Revision    : 1.0 - initial release
// ============================================================================
module exu_div
  import exu_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [REG_W-1:0]      dividend_i,
  input  logic [REG_W-1:0]      divisor_i,
  input  logic [2:0]            op_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  output logic [REG_W-1:0]      result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);

  div_state_e              state_q;
  logic [2:0]              op_q;
  logic [REG_W-1:0]        dvd_q;     // dividend, shifted out MSB first; quotient shifts in at LSB
  logic [REG_W-1:0]        dvs_q;     // divisor (magnitude after START)
  logic [REG_W-1:0]        rem_q;     // partial remainder
  logic [CNT_W-1:0]        cnt_q;
  logic                    quo_neg_q;
  logic                    rem_neg_q;
  logic [REG_W-1:0]        result_q;
  logic                    ready_q;
  logic                    busy_q;
  logic [REG_ADDR_W-1:0]   waddr_q;

  logic                    is_signed;
  logic                    rem_sel;
  logic                    div_zero;
  logic [REG_W:0]          trial;
  logic [REG_W:0]          diff;
  logic                    qbit;
  logic [REG_W-1:0]        rem_d;
  logic [REG_W-1:0]        quo_d;
  logic [REG_W-1:0]        result_d;
`ifdef DIV_SPECIAL_FASTPATH_EN
  logic                    sgn_ovf;
`endif

  always_comb begin
    is_signed = (op_q == INST_DIV) || (op_q == INST_REM);
    rem_sel   = (op_q == INST_REM) || (op_q == INST_REMU);
    div_zero  = (dvs_q == ZERO_WORD);
    // 33-bit trial subtract; bit 32 set means the subtraction went negative
    trial     = {rem_q, dvd_q[REG_W-1]};
    diff      = trial - {1'b0, dvs_q};
    qbit      = ~diff[REG_W];
    rem_d     = qbit ? diff[REG_W-1:0] : trial[REG_W-1:0];
    quo_d     = {dvd_q[REG_W-2:0], qbit};
    result_d  = rem_sel ? neg_if(rem_neg_q, rem_d) : neg_if(quo_neg_q, quo_d);
`ifdef DIV_SPECIAL_FASTPATH_EN
    sgn_ovf   = is_signed && (dvd_q == {1'b1, {(REG_W-1){1'b0}}}) && (dvs_q == ONES_WORD);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dvd_q     <= ZERO_WORD;
      dvs_q     <= ZERO_WORD;
      rem_q     <= ZERO_WORD;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= ZERO_WORD;
      ready_q   <= DIV_RESULT_NOT_READY;
      busy_q    <= 1'b0;
      waddr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q  <= DIV_RESULT_NOT_READY;
          result_q <= ZERO_WORD;
          if ((start_i == DIV_START) && op_i[2]) begin
            op_q    <= op_i;
            dvd_q   <= dividend_i;
            dvs_q   <= divisor_i;
            waddr_q <= reg_waddr_i;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (start_i == DIV_STOP) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`ifdef DIV_SPECIAL_FASTPATH_EN
          // Operands are still the original values here
          else if (div_zero || sgn_ovf) begin
            busy_q   <= 1'b0;
            ready_q  <= DIV_RESULT_READY;
            result_q <= rem_sel ? (div_zero ? dvd_q : ZERO_WORD)
                                : (div_zero ? ONES_WORD : dvd_q);
            state_q  <= S_END;
          end
`endif
          else begin
            dvd_q     <= neg_if(is_signed & dvd_q[REG_W-1], dvd_q);
            dvs_q     <= neg_if(is_signed & dvs_q[REG_W-1], dvs_q);
            // A zero divisor must yield all-ones quotient regardless of signs
            quo_neg_q <= is_signed & (dvd_q[REG_W-1] ^ dvs_q[REG_W-1]) & ~div_zero;
            rem_neg_q <= is_signed & dvd_q[REG_W-1];
            rem_q     <= ZERO_WORD;
            cnt_q     <= '0;
            state_q   <= S_CALC;
          end
        end

        S_CALC: begin
          if (start_i == DIV_STOP) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            dvd_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              busy_q   <= 1'b0;
              ready_q  <= DIV_RESULT_READY;
              result_q <= result_d;
              state_q  <= S_END;
            end
          end
        end

        S_END: begin
          ready_q  <= DIV_RESULT_NOT_READY;
          result_q <= ZERO_WORD;
          state_q  <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign reg_waddr_o = waddr_q;

endmodule
`default_nettype wire

// File: doc/exu_div.md
EXU_DIV -- requirements
Module: exu_div

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset: clk  in  1  core clock; rst  in  1  async active-low reset.
REQ-002 SHALL provide: start_i  in  1  request, held high by controller for whole operation.
REQ-003 SHALL provide: dividend_i  in  32  rs1 value; divisor_i  in  32  rs2 value.
REQ-004 SHALL provide: op_i  in  3  funct3 (100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-005 SHALL provide: reg_waddr_i  in  5  destination register.
REQ-006 SHALL provide: result_o  out  32  quotient/remainder; ready_o  out  1  result-valid pulse; busy_o  out  1  operation in flight; reg_waddr_o  out  5  latched destination.

Function
REQ-007 SHALL implement FSM states IDLE, START, CALC, END.
REQ-008 IDLE: start_i=1 and op_i[2]=1 SHALL latch operands, op, reg_waddr_i and go to START; op_i[2]=0 SHALL be ignored.
REQ-009 START: signed ops SHALL convert operands to magnitudes, record quotient sign (signs differ) and remainder sign (dividend sign), clear counter, go to CALC.
REQ-010 CALC: SHALL perform one restoring step per cycle, MSB first: shift remainder left with next dividend bit, 33-bit trial subtract divisor magnitude, keep if non-negative, quotient bit = non-negative; after 32 steps go to END.
REQ-011 END: SHALL apply sign fixup, drive result_o (quotient for DIV/DIVU, remainder for REM/REMU), assert ready_o for exactly one cycle, return to IDLE.
REQ-012 Latency: start sampled at edge 0 SHALL give ready_o=1 in cycle 34 (1 START + 32 CALC + END).
REQ-013 busy_o SHALL be 1 in START and CALC, 0 in IDLE and END.
REQ-014 result_o SHALL be 0 whenever ready_o=0.
REQ-015 reg_waddr_o SHALL hold the latched destination from START until next accepted start.
REQ-016 start_i low in START or CALC SHALL abort: return to IDLE next cycle, no ready_o, busy_o drops.
REQ-017 Divisor 0: quotient SHALL be 0xFFFFFFFF (DIV and DIVU); remainder SHALL equal original dividend.
REQ-018 DIV/REM with dividend 0x80000000, divisor 0xFFFFFFFF: quotient SHALL be 0x80000000, remainder 0.
REQ-019 start_i high during END SHALL not start a new op; next op is accepted only from IDLE.

Reset
REQ-020 rst low SHALL asynchronously force IDLE, ready_o=0, busy_o=0, result_o=0, reg_waddr_o=0, all internal registers 0.
REQ-021 Reset mid-operation SHALL discard the operation without any ready_o pulse.

Configuration
REQ-022 Macro DIV_SPECIAL_FASTPATH_EN defined: divide-by-zero and signed-overflow cases SHALL bypass CALC, START going directly to END (ready_o in cycle 2).
REQ-023 Macro undefined: those cases SHALL run full 32 CALC steps (ready_o in cycle 34) with identical result values per REQ-017/018.

Structure
REQ-024 Op encodings (INST_DIV/DIVU/REM/REMU), DivStart/DivStop, DivResultReady, ZeroWord and width constants SHALL come from shared defines.v; none redefined locally.
REQ-025 SHALL be a single module; no sub-module is natural (datapath is one subtractor and shift registers).

Verification
REQ-026 DIVU 100/7, hold start_i -> busy_o cycles 1-33, ready_o only in cycle 34, result_o=14, reg_waddr_o=input rd.
REQ-027 REM -7/2 (0xFFFFFFF9, 2) -> result_o=0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD.
REQ-028 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; ready at cycle 2 with DIV_SPECIAL_FASTPATH_EN, cycle 34 without.
REQ-029 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-030 Drop start_i at cycle 10 -> IDLE at cycle 11, busy_o=0, no ready_o; new DIVU 9/3 then -> 3.
REQ-031 Assert rst at cycle 20 -> all outputs 0 immediately, no ready_o after release.
